// File: rtl/queue_dispatcher.sv
// Per-queue circular FIFOs feeding a single registered dispatch stage, driven by an external scheduler grant.
// Optional per-queue saturating dispatch counters are built when QUEUE_DISPATCHER_STATS_EN is defined.
module queue_dispatcher #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int DATA_SIZE        = 64,
    parameter int QUEUE_DEPTH      = 8
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [NUMBER_OF_QUEUES-1:0][DATA_SIZE-1:0]   in_data,
    input  logic [NUMBER_OF_QUEUES-1:0]                  in_valid,
    output logic [NUMBER_OF_QUEUES-1:0]                  in_ready,
    output logic [NUMBER_OF_QUEUES-1:0]                  full,
    output logic [NUMBER_OF_QUEUES-1:0]                  empty,
    input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]          id,
    input  logic                                         valid_and_ready,
    output logic                                         ready,
    output logic [DATA_SIZE-1:0]                         out_data,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]          out_id,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         grant_error,
    output logic [NUMBER_OF_QUEUES-1:0][31:0]            served
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [DATA_SIZE-1:0]        mem   [NUMBER_OF_QUEUES][QUEUE_DEPTH];
    logic [PW-1:0]               head  [NUMBER_OF_QUEUES];
    logic [PW-1:0]               tail  [NUMBER_OF_QUEUES];
    logic [CW-1:0]               count [NUMBER_OF_QUEUES];
    logic [NUMBER_OF_QUEUES-1:0] push;
    logic [NUMBER_OF_QUEUES-1:0] pop_vec;
    logic                        grant_ok;
    logic                        pop;

    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
            full[q]  = (count[q] == DEPTH_C);
            empty[q] = (count[q] == '0);
        end
        in_ready = ~full;
        push     = in_valid & ~full;
        ready    = ~out_valid | out_ready;
        grant_ok = valid_and_ready & ready;
        pop      = grant_ok & ~empty[id];
        pop_vec  = '0;
        if (pop) pop_vec[id] = 1'b1;
    end

    // NOTE: the storage array has no reset; the cleared counts already mark every entry as invalid.
    always_ff @(posedge clock) begin
        for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
            if (push[q]) mem[q][tail[q]] <= in_data[q];
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
                head[q]  <= '0;
                tail[q]  <= '0;
                count[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
                if (push[q])    tail[q] <= tail[q] + PTR_ONE;
                if (pop_vec[q]) head[q] <= head[q] + PTR_ONE;
                case ({push[q], pop_vec[q]})
                    2'b10:   count[q] <= count[q] + CNT_ONE;
                    2'b01:   count[q] <= count[q] - CNT_ONE;
                    default: count[q] <= count[q];
                endcase
            end
        end
    end

    // Output register: a pop reloads it, otherwise an accepted beat empties it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_id      <= '0;
            grant_error <= 1'b0;
        end else begin
            if (pop) begin
                out_valid <= 1'b1;
                out_data  <= mem[id][head[id]];
                out_id    <= id;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (grant_ok && empty[id]) grant_error <= 1'b1;
        end
    end

`ifdef QUEUE_DISPATCHER_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            served <= '0;
        end else begin
            for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
                if (pop_vec[q] && (served[q] != 32'hFFFF_FFFF)) served[q] <= served[q] + 32'd1;
            end
        end
    end
`else
    assign served = '0;
`endif

endmodule
